// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage pipeline.
// Drives the PC and IF/ID, ID/EX, EX/MEM, MEM/WB enables and flushes from the
// cache handshakes, load-use hazards, MEM-stage branches and halt.
// It also keeps saturating stall and branch-flush counters.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_RUN    | normal issue; priority: freeze, branch/halt, load-use, ~ihit
// ST_DWAIT  | data access in MEM still pending; pipeline frozen until dhit
// ST_HALTED | halt retired; only the first cycle lets MEM/WB load
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_branch_taken,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_halt;
  logic             r_halt_first;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mem_op;
  logic w_freeze;
  logic w_load_use;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_mem_op   = mem_dREN | mem_dWEN;
  assign w_freeze   = w_mem_op & ~dhit;
  // $0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_load_use = ex_dREN && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // State register, sticky halt flag and first-halted-cycle marker.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_RUN;
      r_halt       <= 1'b0;
      r_halt_first <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_halt       <= r_halt | (w_state_next == ST_HALTED);
      r_halt_first <= (r_state != ST_HALTED) && (w_state_next == ST_HALTED);
    end
  end

  // Next state plus per-stage enables/flushes in priority order.
  always_comb begin
    w_state_next = r_state;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    case (r_state)
      ST_HALTED: begin
        // The halting instruction still has to move from MEM into WB.
        memwb_en = r_halt_first;
      end
      default: begin
        if (w_freeze) begin
          w_state_next = ST_DWAIT;
          w_stall_inc  = 1'b1;
        end else if (mem_branch_taken || mem_halt) begin
          // Halt reuses the branch squash so nothing younger retires.
          pc_en        = 1'b1;
          ifid_en      = 1'b1;
          idex_en      = 1'b1;
          exmem_en     = 1'b1;
          memwb_en     = 1'b1;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          exmem_flush  = 1'b1;
          w_flush_inc  = mem_branch_taken;
          w_state_next = mem_halt ? ST_HALTED : ST_RUN;
        end else if (w_load_use) begin
          idex_en      = 1'b1;
          idex_flush   = 1'b1;
          exmem_en     = 1'b1;
          memwb_en     = 1'b1;
          w_stall_inc  = 1'b1;
          w_state_next = ST_RUN;
        end else if (!ihit) begin
          ifid_en      = 1'b1;
          ifid_flush   = 1'b1;
          idex_en      = 1'b1;
          exmem_en     = 1'b1;
          memwb_en     = 1'b1;
          w_stall_inc  = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          pc_en        = 1'b1;
          ifid_en      = 1'b1;
          idex_en      = 1'b1;
          exmem_en     = 1'b1;
          memwb_en     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign halt      = r_halt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (4-bit counters so saturation is reachable).
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             CLK;
  logic             RST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, mem_branch_taken, mem_halt;
  logic             ex_dREN, id_uses_rt;
  logic [REG_W-1:0] ex_rt, id_rs, id_rt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // {en[4:0], fl[2:0], halt, stall[3:0], flush[3:0]}
  logic [16:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .mem_branch_taken(mem_branch_taken), .mem_halt(mem_halt),
    .ex_dREN(ex_dREN), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
  always @(negedge CLK) begin
    logic [16:0] got, e;
    string       nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, halt, stall_cnt, flush_cnt};
      n_checks++;
      if (got === e) n_pass++;
      else
        $display("FAIL %s: got en=%b fl=%b halt=%b stall=%0d flush=%0d, expected en=%b fl=%b halt=%b stall=%0d flush=%0d",
                 nm, got[16:12], got[11:9], got[8], got[7:4], got[3:0],
                 e[16:12], e[11:9], e[8], e[7:4], e[3:0]);
    end
  end

  // Apply one cycle of inputs and queue what the outputs must show during it.
  task automatic vec(input string nm,
                     input logic ih, dh, mr, mw, br, mh, ed,
                     input logic [4:0] ert, irs, irt, input logic urt,
                     input logic [4:0] xen, input logic [2:0] xfl, input logic xh,
                     input logic [3:0] xs, xf);
    ihit = ih; dhit = dh; mem_dREN = mr; mem_dWEN = mw;
    mem_branch_taken = br; mem_halt = mh; ex_dREN = ed;
    ex_rt = ert; id_rs = irs; id_rt = irt; id_uses_rt = urt;
    exp_q.push_back({xen, xfl, xh, xs, xf});
    name_q.push_back(nm);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_branch_taken = 0;
    mem_halt = 0; ex_dREN = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    @(posedge CLK); #1;
    do_reset();

    //   name        ih dh mr mw br mh ed ert irs irt urt  en       fl     h  st fl
    vec("reset",      1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 0, 0);
    vec("run",        1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 0, 0);
    vec("lu_rs",      1, 0, 0, 0, 0, 0, 1, 5,  5,  0,  0, 5'b00111, 3'b010, 0, 0, 0);
    vec("lu_clear",   1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 1, 0);
    vec("lu_r0",      1, 0, 0, 0, 0, 0, 1, 0,  0,  0,  1, 5'b11111, 3'b000, 0, 1, 0);
    vec("lu_rt",      1, 0, 0, 0, 0, 0, 1, 7,  3,  7,  1, 5'b00111, 3'b010, 0, 1, 0);
    vec("lu_rt_nouse",1, 0, 0, 0, 0, 0, 1, 7,  3,  7,  0, 5'b11111, 3'b000, 0, 2, 0);
    vec("imiss",      0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b01111, 3'b100, 0, 2, 0);
    vec("imiss_done", 1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 3, 0);
    vec("dwait1",     1, 0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 5'b00000, 3'b000, 0, 3, 0);
    vec("dwait2",     1, 0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 5'b00000, 3'b000, 0, 4, 0);
    vec("dwait3",     1, 0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 5'b00000, 3'b000, 0, 5, 0);
    vec("dhit",       1, 1, 1, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 6, 0);
    vec("after_dw",   1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 6, 0);
    vec("br_prio",    0, 0, 0, 0, 1, 0, 1, 5,  5,  0,  0, 5'b11111, 3'b111, 0, 6, 0);
    vec("after_br",   1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 6, 1);
    vec("br_st_wait1",1, 0, 0, 1, 1, 0, 0, 0,  0,  0,  0, 5'b00000, 3'b000, 0, 6, 1);
    vec("br_st_wait2",1, 0, 0, 1, 1, 0, 0, 0,  0,  0,  0, 5'b00000, 3'b000, 0, 7, 1);
    vec("br_st_dhit", 1, 1, 0, 1, 1, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b111, 0, 8, 1);
    vec("after_br2",  1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 8, 2);
    vec("halt_mem",   1, 0, 0, 0, 0, 1, 0, 0,  0,  0,  0, 5'b11111, 3'b111, 0, 8, 2);
    vec("halted_1st", 1, 0, 0, 0, 1, 0, 0, 0,  0,  0,  0, 5'b00001, 3'b000, 1, 8, 2);
    vec("halted_2nd", 0, 0, 1, 0, 1, 0, 0, 0,  0,  0,  0, 5'b00000, 3'b000, 1, 8, 2);
    vec("halted_ign", 0, 1, 0, 1, 0, 1, 1, 5,  5,  5,  1, 5'b00000, 3'b000, 1, 8, 2);
    do_reset();
    vec("rst_halted", 1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 0, 0);
    vec("dw_pre_rst", 1, 0, 1, 0, 0, 0, 0, 0,  0,  0,  0, 5'b00000, 3'b000, 0, 0, 0);
    do_reset();
    vec("rst_dwait",  1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 0, 0);
    vec("halt_br",    1, 0, 0, 0, 1, 1, 0, 0,  0,  0,  0, 5'b11111, 3'b111, 0, 0, 0);
    vec("halt_br_1st",1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b00001, 3'b000, 1, 0, 1);
    do_reset();
    for (int i = 0; i < 19; i++)
      vec("sat_imiss", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 3'b100, 0,
          (i > 15) ? 4'd15 : 4'(i), 0);
    vec("sat_hold",   1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 5'b11111, 3'b000, 0, 15, 0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
